// File: rtl/ls_issue_queue_pkg.sv
// Shared types for the load/store issue queue: operand bundle, branch mask
// sizing and the branch-resolve helper applied to every held micro-op.
package ls_issue_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int PREG_W           = 6;
  localparam int EBR_MASK_SIZE    = 4;

  // Operand bundle handed to the address-calculation EU
  typedef struct packed {
    logic                     valid;
    logic                     is_store;
    logic [11:0]              imm;
    logic [PREG_W-1:0]        prs1_p;
    logic [PREG_W-1:0]        prs2_p;
    logic                     prs1_rdy;
    logic                     prs2_rdy;
    logic [31:0]              prs1_v;
    logic [31:0]              prs2_v;
    logic [EBR_MASK_SIZE-1:0] ebr_mask;
  } eu_operand_t;

  typedef struct packed {
    logic                     kill;
    logic [EBR_MASK_SIZE-1:0] mask;
  } ebr_res_t;

  // Resolve one op's branch mask: kill on a mispredicted dependency,
  // otherwise drop the resolved branch bit from the mask.
  function automatic ebr_res_t ebr_resolve(
    input logic [EBR_MASK_SIZE-1:0] mask,
    input logic                     done,
    input logic                     mispredict,
    input logic [EBR_MASK_SIZE-1:0] id
  );
    ebr_res_t res;
    res.kill = done && mispredict && ((mask & id) != '0);
    res.mask = (done && !mispredict) ? (mask & ~id) : mask;
    return res;
  endfunction

endpackage

// File: rtl/ls_issue_queue_age_matrix_picker.sv
// Age-matrix oldest-first picker. Row i holds a 1 in column j when entry j
// is older than entry i; an entry wins when no older entry is requesting.
module ls_issue_queue_age_matrix_picker #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_valid,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  logic [N-1:0][N-1:0] r_age;

  // Allocation snapshots the surviving valid set as "older"; allocation or
  // release of a slot clears its column so stale ordering never leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i_alloc[i]) begin
            r_age[i][j] <= (i != j) && i_valid[j] && !i_free[j];
          end else if (i_alloc[j] || i_free[j]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Grant the requester that has no older requester
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_req[i] && ((r_age[i] & i_req) == '0);
    end
  end

endmodule

// File: rtl/ls_issue_queue.sv
// Reservation station for the load/store address EU: holds dispatched ops
// until both sources are ready, wakes them from the CDB, and issues the
// oldest ready op each cycle when the LSQ has credit.
module ls_issue_queue
  import ls_issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int CDB_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 late_flush,
  input  logic                                 dispatch_valid,
  input  eu_operand_t                          dispatch_op,
  output logic                                 iq_full,
  input  logic [CDB_PORTS-1:0]                 cdb_valid,
  input  logic [CDB_PORTS-1:0][PREG_W-1:0]     cdb_tag,
  input  logic [CDB_PORTS-1:0][31:0]           cdb_data,
  input  logic                                 lsq_credit,
  output logic                                 ls_start,
  output eu_operand_t                          ls_in,
  input  logic                                 bra_done,
  input  logic                                 bra_mispredict,
  input  logic [EBR_MASK_SIZE-1:0]             bra_id
);

  logic [DEPTH-1:0] r_valid;
  eu_operand_t      r_op [DEPTH];

  logic [DEPTH-1:0] w_eligible;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_issue;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_free_oh;
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_valid_next;
  eu_operand_t      w_op_next [DEPTH];
  eu_operand_t      w_disp_op;
  ebr_res_t         w_disp_res;
  eu_operand_t      w_issue_op;

  assign iq_full = &r_valid;

  // Incoming op: snoop the CDB for its sources and resolve its branch mask
  always_comb begin
    w_disp_op = dispatch_op;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && !dispatch_op.prs1_rdy && (dispatch_op.prs1_p != '0) &&
          (cdb_tag[p] == dispatch_op.prs1_p)) begin
        w_disp_op.prs1_rdy = 1'b1;
        w_disp_op.prs1_v   = cdb_data[p];
      end
      if (cdb_valid[p] && !dispatch_op.prs2_rdy && (dispatch_op.prs2_p != '0) &&
          (cdb_tag[p] == dispatch_op.prs2_p)) begin
        w_disp_op.prs2_rdy = 1'b1;
        w_disp_op.prs2_v   = cdb_data[p];
      end
    end
    w_disp_res         = ebr_resolve(dispatch_op.ebr_mask, bra_done, bra_mispredict, bra_id);
    w_disp_op.ebr_mask = w_disp_res.mask;
    w_disp_op.valid    = 1'b1;
  end

  // Lowest free slot from registered occupancy
  always_comb begin
    w_free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign w_alloc = (dispatch_valid && !iq_full && !late_flush && !w_disp_res.kill)
                   ? w_free_oh : '0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    eu_operand_t w_woke;
    ebr_res_t    w_res;

    // Held op: wake sources from the CDB and resolve its branch mask
    always_comb begin
      w_woke = r_op[gi];
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && !r_op[gi].prs1_rdy && (r_op[gi].prs1_p != '0) &&
            (cdb_tag[p] == r_op[gi].prs1_p)) begin
          w_woke.prs1_rdy = 1'b1;
          w_woke.prs1_v   = cdb_data[p];
        end
        if (cdb_valid[p] && !r_op[gi].prs2_rdy && (r_op[gi].prs2_p != '0) &&
            (cdb_tag[p] == r_op[gi].prs2_p)) begin
          w_woke.prs2_rdy = 1'b1;
          w_woke.prs2_v   = cdb_data[p];
        end
      end
      w_res           = ebr_resolve(r_op[gi].ebr_mask, bra_done, bra_mispredict, bra_id);
      w_woke.ebr_mask = w_res.mask;
    end

    assign w_eligible[gi]   = r_valid[gi] && r_op[gi].prs1_rdy && r_op[gi].prs2_rdy;
    assign w_kill[gi]       = r_valid[gi] && w_res.kill;
    assign w_valid_next[gi] = w_alloc[gi] || (r_valid[gi] && !w_kill[gi] && !w_issue[gi]);
    assign w_op_next[gi]    = w_alloc[gi] ? w_disp_op : w_woke;
  end

  assign ls_start = (|w_eligible) && lsq_credit && !late_flush;
  assign w_issue  = ls_start ? w_grant : '0;
  assign w_free   = late_flush ? '1 : (w_issue | w_kill);

  ls_issue_queue_age_matrix_picker #(
    .N (DEPTH)
  ) u_picker (
    .clk     (clk),
    .rst     (rst),
    .i_alloc (w_alloc),
    .i_free  (w_free),
    .i_valid (r_valid),
    .i_req   (w_eligible),
    .o_grant (w_grant)
  );

  // Issue mux: the granted entry as stored (mask not yet resolved this cycle)
  always_comb begin
    w_issue_op = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_issue_op = w_issue_op | r_op[i];
    end
    ls_in       = ls_start ? w_issue_op : '0;
    ls_in.valid = ls_start;
  end

  // Entry storage: flush drops everything, otherwise take per-entry next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_op[i] <= '0;
    end else if (late_flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
      for (int i = 0; i < DEPTH; i++) r_op[i] <= w_op_next[i];
    end
  end

  a_no_dispatch_when_full: assert property (
    @(posedge clk) disable iff (rst) !(dispatch_valid && iq_full)
  );

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed bench for ls_issue_queue: dispatch/issue, age order, credit
// gating, branch resolve, flush and mid-run reset.
module tb_ls_issue_queue;
  import ls_issue_queue_pkg::*;

  localparam int DEPTH     = 8;
  localparam int CDB_PORTS = 2;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             late_flush;
  logic                             dispatch_valid;
  eu_operand_t                      dispatch_op;
  logic                             iq_full;
  logic [CDB_PORTS-1:0]             cdb_valid;
  logic [CDB_PORTS-1:0][PREG_W-1:0] cdb_tag;
  logic [CDB_PORTS-1:0][31:0]       cdb_data;
  logic                             lsq_credit;
  logic                             ls_start;
  eu_operand_t                      ls_in;
  logic                             bra_done;
  logic                             bra_mispredict;
  logic [EBR_MASK_SIZE-1:0]         bra_id;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ls_issue_queue #(
    .DEPTH     (DEPTH),
    .CDB_PORTS (CDB_PORTS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .late_flush     (late_flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_op    (dispatch_op),
    .iq_full        (iq_full),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .lsq_credit     (lsq_credit),
    .ls_start       (ls_start),
    .ls_in          (ls_in),
    .bra_done       (bra_done),
    .bra_mispredict (bra_mispredict),
    .bra_id         (bra_id)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic eu_operand_t mk(
    input logic [11:0] imm,
    input logic [PREG_W-1:0] p1, input logic r1, input logic [31:0] v1,
    input logic [PREG_W-1:0] p2, input logic r2, input logic [31:0] v2,
    input logic [EBR_MASK_SIZE-1:0] mask
  );
    eu_operand_t op;
    op          = '0;
    op.valid    = 1'b1;
    op.imm      = imm;
    op.prs1_p   = p1;
    op.prs1_rdy = r1;
    op.prs1_v   = v1;
    op.prs2_p   = p2;
    op.prs2_rdy = r2;
    op.prs2_v   = v2;
    op.ebr_mask = mask;
    return op;
  endfunction

  function automatic eu_operand_t mk_rdy(input logic [11:0] imm, input logic [EBR_MASK_SIZE-1:0] mask);
    return mk(imm, 6'd1, 1'b1, 32'h1000_0000 | {20'h0, imm},
              6'd2, 1'b1, 32'h2000_0000 | {20'h0, imm}, mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input string tag, input logic [11:0] imm);
    chk({tag, ".start"}, 128'(ls_start), 128'(1'b1));
    chk({tag, ".imm"}, 128'(ls_in.imm), 128'(imm));
  endtask

  task automatic idle_inputs();
    late_flush     = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_op    = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_data       = '0;
    bra_done       = 1'b0;
    bra_mispredict = 1'b0;
    bra_id         = '0;
  endtask

  initial begin
    idle_inputs();
    lsq_credit = 1'b1;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state (credit high so ls_start is not trivially masked)
    chk("rst.iq_full", 128'(iq_full), 128'(1'b0));
    chk("rst.ls_start", 128'(ls_start), 128'(1'b0));
    chk("rst.ls_in", 128'(ls_in), 128'(0));
    rst = 1'b0;

    // both sources ready, issue next cycle
    dispatch_valid = 1'b1;
    dispatch_op    = mk_rdy(12'h001, 4'b0000);
    #1;
    chk("rdy.same_cycle", 128'(ls_start), 128'(1'b0));
    tick();
    dispatch_valid = 1'b0;
    #1;
    expect_issue("rdy.issue", 12'h001);
    chk("rdy.v1", 128'(ls_in.prs1_v), 128'(32'h1000_0001));
    chk("rdy.v2", 128'(ls_in.prs2_v), 128'(32'h2000_0001));
    tick();
    chk("rdy.empty", 128'(ls_start), 128'(1'b0));

    // CDB snooped on the dispatch path
    dispatch_valid = 1'b1;
    dispatch_op    = mk(12'h002, 6'd9, 1'b0, 32'h0, 6'd2, 1'b1, 32'h22, 4'b0000);
    cdb_valid      = 2'b10;
    cdb_tag[1]     = 6'd9;
    cdb_data[1]    = 32'h0000_BEEF;
    #1;
    chk("snoop.same_cycle", 128'(ls_start), 128'(1'b0));
    tick();
    idle_inputs();
    #1;
    expect_issue("snoop.issue", 12'h002);
    chk("snoop.v1", 128'(ls_in.prs1_v), 128'(32'h0000_BEEF));
    tick();

    // age order: A waits on p5, B and C ready; p5 arrives late
    dispatch_valid = 1'b1;
    dispatch_op    = mk(12'h00A, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 4'b0000);
    tick();
    dispatch_op = mk_rdy(12'h00B, 4'b0000);
    #1;
    chk("age.a_waits", 128'(ls_start), 128'(1'b0));
    tick();
    dispatch_op = mk_rdy(12'h00C, 4'b0000);
    #1;
    expect_issue("age.first_b", 12'h00B);
    tick();
    dispatch_valid = 1'b0;
    cdb_valid      = 2'b01;
    cdb_tag[0]     = 6'd5;
    cdb_data[0]    = 32'h0000_1000;
    #1;
    expect_issue("age.second_c", 12'h00C);
    tick();
    idle_inputs();
    #1;
    expect_issue("age.third_a", 12'h00A);
    chk("age.a_v1", 128'(ls_in.prs1_v), 128'(32'h0000_1000));
    tick();
    chk("age.empty", 128'(ls_start), 128'(1'b0));

    // credit gating: fill, then drain oldest first
    lsq_credit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      dispatch_valid = 1'b1;
      dispatch_op    = mk_rdy(12'h020 + 12'(k), 4'b0000);
      #1;
      chk("credit.fill_no_start", 128'(ls_start), 128'(1'b0));
      tick();
    end
    dispatch_valid = 1'b0;
    #1;
    chk("credit.full", 128'(iq_full), 128'(1'b1));
    chk("credit.held", 128'(ls_start), 128'(1'b0));
    lsq_credit = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      expect_issue("credit.drain", 12'h020 + 12'(k));
      tick();
    end
    chk("credit.drained", 128'(ls_start), 128'(1'b0));
    chk("credit.not_full", 128'(iq_full), 128'(1'b0));

    // age differs from index: S lands in slot 0 but is youngest
    lsq_credit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dispatch_valid = 1'b1;
      dispatch_op    = mk_rdy(12'h030 + 12'(k), 4'b0000);
      tick();
    end
    dispatch_valid = 1'b0;
    lsq_credit     = 1'b1;
    #1;
    expect_issue("reuse.p", 12'h030);
    tick();
    lsq_credit     = 1'b0;
    dispatch_valid = 1'b1;
    dispatch_op    = mk_rdy(12'h033, 4'b0000);
    tick();
    dispatch_valid = 1'b0;
    lsq_credit     = 1'b1;
    #1;
    expect_issue("reuse.q", 12'h031);
    tick();
    expect_issue("reuse.r", 12'h032);
    tick();
    expect_issue("reuse.s", 12'h033);
    tick();
    chk("reuse.empty", 128'(ls_start), 128'(1'b0));

    // mispredict on branch 0001; same-cycle dispatch under it is dropped
    lsq_credit = 1'b0;
    dispatch_valid = 1'b1;
    dispatch_op = mk_rdy(12'h041, 4'b0001); tick();
    dispatch_op = mk_rdy(12'h042, 4'b0010); tick();
    dispatch_op = mk_rdy(12'h043, 4'b0011); tick();
    dispatch_op    = mk_rdy(12'h044, 4'b0001);
    bra_done       = 1'b1;
    bra_mispredict = 1'b1;
    bra_id         = 4'b0001;
    tick();
    idle_inputs();
    lsq_credit = 1'b1;
    #1;
    expect_issue("misp.survivor", 12'h042);
    chk("misp.mask", 128'(ls_in.ebr_mask), 128'(4'b0010));
    tick();
    chk("misp.only_one", 128'(ls_start), 128'(1'b0));

    // correct prediction on branch 0001: bit cleared everywhere
    lsq_credit = 1'b0;
    dispatch_valid = 1'b1;
    dispatch_op = mk_rdy(12'h041, 4'b0001); tick();
    dispatch_op = mk_rdy(12'h042, 4'b0010); tick();
    dispatch_op = mk_rdy(12'h043, 4'b0011); tick();
    dispatch_op    = mk_rdy(12'h044, 4'b0001);
    bra_done       = 1'b1;
    bra_mispredict = 1'b0;
    bra_id         = 4'b0001;
    tick();
    idle_inputs();
    lsq_credit = 1'b1;
    #1;
    expect_issue("res.e1", 12'h041);
    chk("res.e1_mask", 128'(ls_in.ebr_mask), 128'(4'b0000));
    tick();
    expect_issue("res.e2", 12'h042);
    chk("res.e2_mask", 128'(ls_in.ebr_mask), 128'(4'b0010));
    tick();
    expect_issue("res.e3", 12'h043);
    chk("res.e3_mask", 128'(ls_in.ebr_mask), 128'(4'b0010));
    tick();
    expect_issue("res.e4", 12'h044);
    chk("res.e4_mask", 128'(ls_in.ebr_mask), 128'(4'b0000));
    tick();
    chk("res.empty", 128'(ls_start), 128'(1'b0));

    // dispatch + CDB match + late_flush together, with one op already held
    lsq_credit     = 1'b0;
    dispatch_valid = 1'b1;
    dispatch_op    = mk_rdy(12'h050, 4'b0000);
    tick();
    dispatch_op = mk(12'h051, 6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 4'b0000);
    cdb_valid   = 2'b01;
    cdb_tag[0]  = 6'd7;
    cdb_data[0] = 32'h0000_7777;
    late_flush  = 1'b1;
    lsq_credit  = 1'b1;
    #1;
    chk("flush.gated", 128'(ls_start), 128'(1'b0));
    tick();
    idle_inputs();
    #1;
    chk("flush.no_start", 128'(ls_start), 128'(1'b0));
    chk("flush.not_full", 128'(iq_full), 128'(1'b0));
    tick();
    chk("flush.still_empty", 128'(ls_start), 128'(1'b0));

    // mid-run reset with a full queue
    lsq_credit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      dispatch_valid = 1'b1;
      dispatch_op    = mk_rdy(12'h060 + 12'(k), 4'b0000);
      tick();
    end
    dispatch_valid = 1'b0;
    #1;
    chk("rst2.full_before", 128'(iq_full), 128'(1'b1));
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    lsq_credit = 1'b1;
    #1;
    chk("rst2.not_full", 128'(iq_full), 128'(1'b0));
    chk("rst2.no_start", 128'(ls_start), 128'(1'b0));
    chk("rst2.ls_in", 128'(ls_in), 128'(0));
    tick();
    chk("rst2.still_idle", 128'(ls_start), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
